// File: rtl/pll_lock_sequencer_if.sv
// Handshake bundle between the PLL lock sequencer and its PLL / core-reset consumers.
// The slave view belongs to the sequencer; the master view drives lock and restart.
interface pll_lock_sequencer_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             pll_locked;
    logic             restart;
    logic             pll_areset;
    logic             core_rst_n;
    logic             ready;
    logic             fail;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [2:0]       state;

    modport master (
        output pll_locked,
        output restart,
        input  pll_areset,
        input  core_rst_n,
        input  ready,
        input  fail,
        input  lock_loss_cnt,
        input  state
    );

    modport slave (
        input  pll_locked,
        input  restart,
        output pll_areset,
        output core_rst_n,
        output ready,
        output fail,
        output lock_loss_cnt,
        output state
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up supervisor on the reference clock: pulses the PLL reset, waits for lock with
// timeout/retry, qualifies lock over a stable window, then releases the core reset.
module pll_lock_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pll_lock_sequencer_if.slave   seq_if
);

    localparam int unsigned MaxA   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES
                                                                     : LOCK_TIMEOUT;
    localparam int unsigned MaxCyc = (MaxA > STABLE_CYCLES) ? MaxA : STABLE_CYCLES;
    localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [TimerW-1:0] RstLast    = TimerW'(PLL_RST_CYCLES - 1);
    localparam logic [TimerW-1:0] WaitLast   = TimerW'(LOCK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] StableLast = TimerW'(STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [RetryW-1:0] retry_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sync1_q, locked_s_q;
    logic              pll_areset_q, core_rst_n_q, fail_q;
    logic              lock_lost;

    // pll_locked is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= seq_if.pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        retry_inc = retry_q + 1'b1;
        lock_lost = (state_q == StRun) && !locked_s_q;

        // Counted even when restart wins the transition
        if (lock_lost && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (seq_if.restart) begin
            state_d = StPllRst;
            timer_d = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StPllRst: begin
                    if (timer_q == RstLast) begin
                        state_d = StWaitLock;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (locked_s_q) begin
                        state_d = StStable;
                        timer_d = '0;
                    end else if (timer_q == WaitLast) begin
                        retry_d = retry_inc;
                        timer_d = '0;
                        state_d = (retry_inc == RetryMax) ? StFail : StPllRst;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StStable: begin
                    if (!locked_s_q) begin
                        state_d = StWaitLock;
                        timer_d = '0;
                    end else if (timer_q == StableLast) begin
                        state_d = StRun;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StRun: begin
                    if (lock_lost) begin
                        state_d = StPllRst;
                        timer_d = '0;
                    end
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d = StPllRst;
                    timer_d = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StPllRst;
            timer_q      <= '0;
            retry_q      <= '0;
            cnt_q        <= '0;
            pll_areset_q <= 1'b1;
            core_rst_n_q <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            cnt_q        <= cnt_d;
            pll_areset_q <= (state_d == StPllRst) || (state_d == StFail);
            core_rst_n_q <= (state_d == StRun);
            fail_q       <= (state_d == StFail);
        end
    end

    assign seq_if.pll_areset    = pll_areset_q;
    assign seq_if.core_rst_n    = core_rst_n_q;
    assign seq_if.ready         = core_rst_n_q;
    assign seq_if.fail          = fail_q;
    assign seq_if.lock_loss_cnt = cnt_q;
    assign seq_if.state         = state_q;

endmodule
